// File: rtl/rand_word_packer_if.sv
// Bit-in / word-out bus for rand_word_packer.
// slave is the packer side, master is the driver/consumer side.
interface rand_word_packer_if #(
  parameter int WORD_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) ();
  logic                          bit_in;
  logic                          bit_valid;
  logic [WORD_BITS-1:0]          word_data;
  logic                          word_valid;
  logic                          word_ready;
  logic [$clog2(FIFO_DEPTH):0]   fill_level;
  logic                          overflow;
  logic                          overflow_clr;

  modport slave (
    input  bit_in, bit_valid, word_ready, overflow_clr,
    output word_data, word_valid, fill_level, overflow
  );

  modport master (
    output bit_in, bit_valid, word_ready, overflow_clr,
    input  word_data, word_valid, fill_level, overflow
  );
endinterface

// File: rtl/rand_word_packer.sv
// Packs a serial random bit stream MSB-first into words and queues them in a show-ahead FIFO.
// Optional von Neumann debias front end: define RAND_WORD_PACKER_DEBIAS_EN.
module rand_word_packer #(
  parameter int WORD_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  rand_word_packer_if.slave     bus
);
  localparam int CW = $clog2(WORD_BITS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;

  logic [WORD_BITS-1:0] mem_r [FIFO_DEPTH];
  logic [WORD_BITS-1:0] shreg_r;
  logic [WORD_BITS-1:0] word_nx_s;
  logic [WORD_BITS-1:0] word_data_r;
  logic [CW-1:0]        bit_cnt_r;
  logic [PW-1:0]        wr_ptr_r;
  logic [PW-1:0]        rd_ptr_r;
  logic [PW-1:0]        rd_nx_s;
  logic [LW-1:0]        fill_r;
  logic [LW-1:0]        fill_nx_s;
  logic                 word_valid_r;
  logic                 overflow_r;
  logic                 feed_valid_s;
  logic                 feed_bit_s;
  logic                 complete_s;
  logic                 push_s;
  logic                 pop_s;
  logic                 drop_s;

`ifdef RAND_WORD_PACKER_DEBIAS_EN
  localparam logic [0:0] ST_IDLE       = 1'b0;
  localparam logic [0:0] ST_HAVE_FIRST = 1'b1;

  logic [0:0] state_r;
  logic       first_r;

  // Unequal pairs emit their first bit (10 -> 1, 01 -> 0); equal pairs emit nothing.
  always_comb begin
    feed_valid_s = 1'b0;
    feed_bit_s   = first_r;
    case (state_r)
      ST_IDLE:       feed_valid_s = 1'b0;
      ST_HAVE_FIRST: feed_valid_s = bus.bit_valid && (first_r != bus.bit_in);
      default:       feed_valid_s = 1'b0;
    endcase
  end

  // Debias pairing FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      first_r <= 1'b0;
    end else if (bus.bit_valid) begin
      case (state_r)
        ST_IDLE: begin
          first_r <= bus.bit_in;
          state_r <= ST_HAVE_FIRST;
        end
        ST_HAVE_FIRST: state_r <= ST_IDLE;
        default:       state_r <= ST_IDLE;
      endcase
    end else begin
      state_r <= state_r;
    end
  end
`else
  assign feed_valid_s = bus.bit_valid;
  assign feed_bit_s   = bus.bit_in;
`endif

  assign word_nx_s  = {shreg_r[WORD_BITS-2:0], feed_bit_s};
  assign complete_s = feed_valid_s && (bit_cnt_r == CW'(WORD_BITS - 1));
  assign pop_s      = word_valid_r && bus.word_ready;
  // A full FIFO still accepts the new word when the head leaves on the same edge.
  assign push_s     = complete_s && ((fill_r != LW'(FIFO_DEPTH)) || pop_s);
  assign drop_s     = complete_s && !push_s;

  // Next occupancy and read pointer, shared by the FIFO and the registered head.
  always_comb begin
    fill_nx_s = fill_r;
    rd_nx_s   = rd_ptr_r;
    case ({push_s, pop_s})
      2'b10:   fill_nx_s = fill_r + LW'(1);
      2'b01:   fill_nx_s = fill_r - LW'(1);
      default: fill_nx_s = fill_r;
    endcase
    if (pop_s) begin
      rd_nx_s = rd_ptr_r + PW'(1);
    end else begin
      rd_nx_s = rd_ptr_r;
    end
  end

  // Serial assembler.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_r   <= '0;
      bit_cnt_r <= '0;
    end else if (feed_valid_s) begin
      shreg_r <= word_nx_s;
      if (complete_s) begin
        bit_cnt_r <= '0;
      end else begin
        bit_cnt_r <= bit_cnt_r + CW'(1);
      end
    end else begin
      shreg_r   <= shreg_r;
      bit_cnt_r <= bit_cnt_r;
    end
  end

  // FIFO storage, pointers, occupancy and registered show-ahead head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r     <= '0;
      rd_ptr_r     <= '0;
      fill_r       <= '0;
      word_valid_r <= 1'b0;
      word_data_r  <= '0;
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= word_nx_s;
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      rd_ptr_r     <= rd_nx_s;
      fill_r       <= fill_nx_s;
      word_valid_r <= (fill_nx_s != LW'(0));
      // The new word can only become head when it lands in an empty FIFO.
      if (fill_nx_s == LW'(0)) begin
        word_data_r <= word_data_r;
      end else if (push_s && (wr_ptr_r == rd_nx_s)) begin
        word_data_r <= word_nx_s;
      end else begin
        word_data_r <= mem_r[rd_nx_s];
      end
    end
  end

  // Sticky overflow; a drop outranks a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else if (bus.overflow_clr) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  assign bus.word_data  = word_data_r;
  assign bus.word_valid = word_valid_r;
  assign bus.fill_level = fill_r;
  assign bus.overflow   = overflow_r;
endmodule

// File: tb/tb_rand_word_packer.sv
// Directed bench for rand_word_packer (WORD_BITS=8, FIFO_DEPTH=4), default build or with
// RAND_WORD_PACKER_DEBIAS_EN, where each data bit is sent as a 10/01 pair.
module tb_rand_word_packer;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  rand_word_packer_if #(.WORD_BITS(8), .FIFO_DEPTH(4)) bus ();

  rand_word_packer #(.WORD_BITS(8), .FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] bits;
    logic [7:0] exp_data;
    logic [2:0] exp_fill;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.bit_in    = b;
    bus.bit_valid = 1'b1;
    step();
    bus.bit_valid = 1'b0;
  endtask

  // word_ready/overflow_clr take rdy_fin/clr_fin for the edge that delivers the bit.
  task automatic send_data_bit(input logic b, input logic rdy_fin, input logic clr_fin);
`ifdef RAND_WORD_PACKER_DEBIAS_EN
    send_bit(b);
    bus.word_ready   = rdy_fin;
    bus.overflow_clr = clr_fin;
    send_bit(~b);
`else
    bus.word_ready   = rdy_fin;
    bus.overflow_clr = clr_fin;
    send_bit(b);
`endif
    bus.overflow_clr = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input logic rdy_last, input logic clr_last);
    for (int b = 7; b >= 1; b--) send_data_bit(w[b], bus.word_ready, 1'b0);
    send_data_bit(w[0], rdy_last, clr_last);
  endtask

  task automatic pop_one();
    bus.word_ready = 1'b1;
    step();
    bus.word_ready = 1'b0;
  endtask

  logic [7:0] exp_q [4];

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.bit_in = 1'b0;
    bus.bit_valid = 1'b0;
    bus.word_ready = 1'b0;
    bus.overflow_clr = 1'b0;

    vecs[0] = '{bits: 8'b1011_0010, exp_data: 8'hB2, exp_fill: 3'd1};
    vecs[1] = '{bits: 8'b0000_0000, exp_data: 8'h00, exp_fill: 3'd1};
    vecs[2] = '{bits: 8'b1111_1111, exp_data: 8'hFF, exp_fill: 3'd1};
    vecs[3] = '{bits: 8'b0101_1010, exp_data: 8'h5A, exp_fill: 3'd1};
    vecs[4] = '{bits: 8'b1000_0001, exp_data: 8'h81, exp_fill: 3'd1};

    repeat (2) step();
    chk("reset_valid", {31'd0, bus.word_valid}, 32'd0);
    chk("reset_fill", {29'd0, bus.fill_level}, 32'd0);
    chk("reset_ovf", {31'd0, bus.overflow}, 32'd0);
    chk("reset_data", {24'd0, bus.word_data}, 32'd0);
    rst_n = 1'b1;
    step();

    // Streaming words with the consumer always ready.
    bus.word_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      for (int b = 7; b >= 0; b--) begin
        send_data_bit(vecs[v].bits[b], 1'b1, 1'b0);
        if (b == 1) chk("valid_before_last", {31'd0, bus.word_valid}, 32'd0);
      end
      chk("vec_valid", {31'd0, bus.word_valid}, 32'd1);
      chk("vec_data", {24'd0, bus.word_data}, {24'd0, vecs[v].exp_data});
      chk("vec_fill", {29'd0, bus.fill_level}, {29'd0, vecs[v].exp_fill});
    end
    step();
    bus.word_ready = 1'b0;
    chk("drain_valid", {31'd0, bus.word_valid}, 32'd0);
    chk("drain_fill", {29'd0, bus.fill_level}, 32'd0);
    chk("empty_hold_data", {24'd0, bus.word_data}, 32'h81);

    // Five words into a blocked FIFO: the fifth is dropped.
    for (int w = 1; w <= 5; w++) send_word(8'(w), 1'b0, 1'b0);
    chk("ovf_fill", {29'd0, bus.fill_level}, 32'd4);
    chk("ovf_set", {31'd0, bus.overflow}, 32'd1);
    for (int i = 1; i <= 4; i++) begin
      chk("ovf_pop_data", {24'd0, bus.word_data}, i);
      pop_one();
    end
    chk("ovf_empty", {31'd0, bus.word_valid}, 32'd0);
    chk("ovf_sticky", {31'd0, bus.overflow}, 32'd1);
    bus.overflow_clr = 1'b1;
    step();
    bus.overflow_clr = 1'b0;
    chk("ovf_clr", {31'd0, bus.overflow}, 32'd0);
    send_word(8'hA7, 1'b0, 1'b0);
    chk("restart_data", {24'd0, bus.word_data}, 32'hA7);
    chk("restart_fill", {29'd0, bus.fill_level}, 32'd1);
    pop_one();

    // Full FIFO with a pop on the completing edge of the fifth word.
    send_word(8'h11, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b0);
    send_word(8'h33, 1'b0, 1'b0);
    send_word(8'h44, 1'b0, 1'b0);
    chk("full_fill", {29'd0, bus.fill_level}, 32'd4);
    send_word(8'h55, 1'b1, 1'b0);
    bus.word_ready = 1'b0;
    chk("pushpop_fill", {29'd0, bus.fill_level}, 32'd4);
    chk("pushpop_ovf", {31'd0, bus.overflow}, 32'd0);
    exp_q = '{8'h22, 8'h33, 8'h44, 8'h55};
    for (int i = 0; i < 4; i++) begin
      chk("pushpop_data", {24'd0, bus.word_data}, {24'd0, exp_q[i]});
      pop_one();
    end
    chk("pushpop_empty", {29'd0, bus.fill_level}, 32'd0);

    // Clear coincident with a drop: drop wins.
    for (int w = 16; w <= 19; w++) send_word(8'(w), 1'b0, 1'b0);
    send_word(8'h14, 1'b0, 1'b1);
    chk("clr_vs_drop", {31'd0, bus.overflow}, 32'd1);
    chk("clr_vs_drop_head", {24'd0, bus.word_data}, 32'h10);

    // Reset mid-word with a full FIFO and overflow set.
    send_data_bit(1'b1, 1'b0, 1'b0);
    send_data_bit(1'b1, 1'b0, 1'b0);
    send_data_bit(1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    chk("rst_valid", {31'd0, bus.word_valid}, 32'd0);
    chk("rst_fill", {29'd0, bus.fill_level}, 32'd0);
    chk("rst_ovf", {31'd0, bus.overflow}, 32'd0);
    chk("rst_data", {24'd0, bus.word_data}, 32'd0);
    step();
    rst_n = 1'b1;
    send_word(8'hC3, 1'b0, 1'b0);
    chk("post_rst_valid", {31'd0, bus.word_valid}, 32'd1);
    chk("post_rst_data", {24'd0, bus.word_data}, 32'hC3);
    chk("post_rst_fill", {29'd0, bus.fill_level}, 32'd1);
    pop_one();
    chk("post_rst_empty", {29'd0, bus.fill_level}, 32'd0);

`ifdef RAND_WORD_PACKER_DEBIAS_EN
    // Raw pairs 01,10,11,00 x4 give data bits 0,1 per round -> 0x55.
    for (int r = 0; r < 4; r++) begin
      send_bit(1'b0); send_bit(1'b1);
      send_bit(1'b1); send_bit(1'b0);
      send_bit(1'b1); send_bit(1'b1);
      send_bit(1'b0); send_bit(1'b0);
    end
    chk("debias_valid", {31'd0, bus.word_valid}, 32'd1);
    chk("debias_data", {24'd0, bus.word_data}, 32'h55);
    send_bit(1'b1); send_bit(1'b1);
    send_bit(1'b0); send_bit(1'b0);
    chk("debias_equal_pairs", {29'd0, bus.fill_level}, 32'd1);
    send_word(8'h0F, 1'b0, 1'b0);
    chk("debias_fill2", {29'd0, bus.fill_level}, 32'd2);
    pop_one();
    chk("debias_next_word", {24'd0, bus.word_data}, 32'h0F);
    pop_one();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rand_word_packer.md
RAND_WORD_PACKER -- requirements
Module: rand_word_packer

Interface
REQ-001 Parameter WORD_BITS, default 8: width of each assembled output word, minimum 2.
REQ-002 Parameter FIFO_DEPTH, default 4: output FIFO entries; a power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 bit_in  input  1  serial random bit from the upstream LFSR.
REQ-006 bit_valid  input  1  bit_in is sampled on rising edges where bit_valid=1.
REQ-007 word_data  output  WORD_BITS  FIFO head word.
REQ-008 word_valid  output  1  high while the FIFO is non-empty.
REQ-009 word_ready  input  1  consumer accepts the head word on an edge where word_valid=1 and word_ready=1.
REQ-010 fill_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-011 overflow  output  1  sticky: a completed word was dropped.
REQ-012 overflow_clr  input  1  synchronous clear of overflow.

Function
REQ-013 The assembler shifts each accepted bit in MSB-first: shreg <= {shreg[WORD_BITS-2:0], bit}.
REQ-014 bit_cnt counts accepted bits from 0 to WORD_BITS-1 and wraps to 0 on the edge that completes a word.
REQ-015 On the completing edge, {shreg[WORD_BITS-2:0], bit} is pushed to the FIFO; word_valid rises the next cycle (latency 1 from the last bit).
REQ-016 The FIFO is show-ahead: word_data is driven directly from the head entry with no read latency.
REQ-017 Pop occurs on edges where word_valid=1 and word_ready=1; the head advances and fill_level decrements.
REQ-018 Push is allowed when fill_level<FIFO_DEPTH, or when fill_level==FIFO_DEPTH and a pop occurs on the same edge.
REQ-019 A simultaneous push and pop leaves fill_level unchanged.
REQ-020 A completing word with no room is discarded, FIFO contents are unchanged, and overflow is set the next cycle.
REQ-021 The assembler restarts at bit_cnt=0 after a dropped word.
REQ-022 overflow_clr=1 clears overflow; if a drop occurs on the same edge, the drop wins and overflow stays 1.
REQ-023 Read and write pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
REQ-024 Full is fill_level==FIFO_DEPTH and empty is fill_level==0.
REQ-025 word_data holds its last value while empty; it is not a valid word.
REQ-026 When bit_valid=0, no assembler state changes.

Reset
REQ-027 While rst_n=0: shreg=0, bit_cnt=0, pointers=0, fill_level=0, word_valid=0, overflow=0, debias state=IDLE.
REQ-028 Reset mid-word discards the partial word and all FIFO contents.
REQ-029 The first bit accepted after rst_n deasserts is the MSB of a new word.

Configuration
REQ-030 Macro RAND_WORD_PACKER_DEBIAS_EN compiles in a von Neumann debias stage between bit_in and the assembler.
REQ-031 With RAND_WORD_PACKER_DEBIAS_EN defined, the debias stage is a two-state FSM.
  - IDLE: an accepted bit is stored as first; go to HAVE_FIRST.
  - HAVE_FIRST: on the next accepted bit, pair 01 feeds 0 to the assembler, pair 10 feeds 1, and pairs 00/11 feed nothing; return to IDLE.
  - The assembler accepts the fed bit on that same edge.
REQ-032 Without RAND_WORD_PACKER_DEBIAS_EN, every accepted bit_in goes straight to the assembler and no debias logic exists.

Verification
REQ-033 WORD_BITS=8, bits 1,0,1,1,0,0,1,0 with bit_valid=1 and word_ready=1 -> word_data=0xB2 and word_valid=1 exactly one cycle after the 8th bit.
REQ-034 word_ready=0, 5 full words supplied (0x01,0x02,0x03,0x04,0x05) -> fill_level=4, overflow=1, pops return 0x01..0x04, and 0x05 is never seen.
REQ-035 FIFO full, word_ready=1 on the edge a 5th word completes -> fill_level stays 4, overflow=0, and the 5th word is last out.
REQ-036 rst_n pulsed low after 3 bits of a word -> all outputs 0; the next 8 bits form a complete fresh word.
REQ-037 DEBIAS_EN defined, bit pairs 01,10,11,00 repeated 4 times -> one word 0x55 after 16 pairs, no extra bits.
REQ-038 overflow=1, overflow_clr pulse with no new drop -> overflow=0 next cycle; clr coincident with a drop -> overflow stays 1.
